decode_stage: RTL and testbench

Pipelined, parametrised instruction decode stage for the RV64/RV32 core. It sits between fetch and execute. It takes a raw 32-bit instruction plus its PC through a valid/ready handshake and classifies the opcode into one-hot type flags and unit enables. It extracts register fields and builds the XLEN-wide sign-extended immediate, flags illegal encodings, and hands the result downstream through a registered two-entry skid buffer with flush support.

---
 rtl/decode_pkg.sv | 66 ++++++
 rtl/decode_skid_buf.sv | 66 ++++++
 rtl/decode_stage.sv | 114 +++++++++++
 tb/tb_decode_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared constants and the decoded-entry record for the decode stage.
// Entries are sized for the widest datapath; narrower cores use the low bits.
package decode_pkg;

    localparam int MAX_XLEN = 64;
    localparam int TYPE_W   = 12;
    localparam int UNIT_W   = 5;
    localparam int OPC_W    = 7;

    localparam logic [OPC_W-1:0] OP_R_ALU64   = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_R_ALU32   = 7'b0111011;
    localparam logic [OPC_W-1:0] OP_I_ALU64   = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_I_ALU32   = 7'b0011011;
    localparam logic [OPC_W-1:0] OP_I_MEMLOAD = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_I_ENV     = 7'b1110011;
    localparam logic [OPC_W-1:0] OP_I_JALR    = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_S_STORE   = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_B_BRANCH  = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_U_AUIPC   = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_U_LUI     = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_J_JAL     = 7'b1101111;

    localparam int T_R_ALU64   = 11;
    localparam int T_R_ALU32   = 10;
    localparam int T_I_ALU64   = 9;
    localparam int T_I_ALU32   = 8;
    localparam int T_I_MEMLOAD = 7;
    localparam int T_I_ENV     = 6;
    localparam int T_I_JALR    = 5;
    localparam int T_S_STORE   = 4;
    localparam int T_B_BRANCH  = 3;
    localparam int T_U_AUIPC   = 2;
    localparam int T_U_LUI     = 1;
    localparam int T_J_JAL     = 0;

    localparam int U_ALU  = 4;
    localparam int U_MEM  = 3;
    localparam int U_ENV  = 2;
    localparam int U_JUMP = 1;
    localparam int U_UIMM = 0;

    // Opcode slot k of this table corresponds to out_type bit k.
    localparam logic [TYPE_W*OPC_W-1:0] OPC_TABLE = {
        OP_R_ALU64, OP_R_ALU32, OP_I_ALU64, OP_I_ALU32,
        OP_I_MEMLOAD, OP_I_ENV, OP_I_JALR, OP_S_STORE,
        OP_B_BRANCH, OP_U_AUIPC, OP_U_LUI, OP_J_JAL
    };

    typedef struct packed {
        logic [MAX_XLEN-1:0] pc;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [TYPE_W-1:0]   itype;
        logic [UNIT_W-1:0]   unit;
        logic [MAX_XLEN-1:0] imm;
        logic                illegal;
    } entry_t;

    function automatic logic [MAX_XLEN-1:0] sext32(input logic [31:0] v);
        return {{(MAX_XLEN-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/decode_skid_buf.sv
// Two-entry valid/ready buffer: main register drives the output, skid absorbs
// one extra beat so in_ready is a pure register with no path from out_ready.
module decode_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept, drain;

    assign accept    = in_valid & ~skid_valid_q;
    assign drain     = main_valid_q & out_ready;
    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_q;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain && skid_valid_q) begin
            // No accept can coincide here: skid full means in_ready is low.
            main_d       = skid_q;
            skid_valid_d = 1'b0;
        end else if (accept && (!main_valid_q || drain)) begin
            main_d       = in_data;
            main_valid_d = 1'b1;
        end else if (accept) begin
            skid_d       = in_data;
            skid_valid_d = 1'b1;
        end else if (drain) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode: opcode classification, field extraction and immediate
// generation, registered through a two-entry skid buffer.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [2:0]        out_funct3,
    output logic [6:0]        out_funct7,
    output logic [TYPE_W-1:0] out_type,
    output logic [UNIT_W-1:0] out_unit,
    output logic [XLEN-1:0]   out_imm,
    output logic              out_illegal
);

    logic [OPC_W-1:0]  opcode;
    logic [TYPE_W-1:0] hit;
    logic              illegal;
    logic [31:0]       imm32;
    logic [UNIT_W-1:0] unit;
    entry_t            dec_entry, out_entry;

    assign opcode = in_inst[6:0];

    for (genvar gi = 0; gi < TYPE_W; gi++) begin : g_opc_match
        assign hit[gi] = (opcode == OPC_TABLE[gi*OPC_W +: OPC_W]);
    end

    // The 32-bit datapath has no W-suffixed operations.
    assign illegal = (in_inst[1:0] != 2'b11) || (hit == '0) ||
                     ((XLEN == 32) && (hit[T_R_ALU32] || hit[T_I_ALU32]));

    always_comb begin
        unit         = '0;
        unit[U_ALU]  = hit[T_R_ALU64] | hit[T_R_ALU32] | hit[T_I_ALU64] | hit[T_I_ALU32];
        unit[U_MEM]  = hit[T_I_MEMLOAD] | hit[T_S_STORE];
        unit[U_ENV]  = hit[T_I_ENV];
        unit[U_JUMP] = hit[T_I_JALR] | hit[T_B_BRANCH] | hit[T_J_JAL];
        unit[U_UIMM] = hit[T_U_AUIPC] | hit[T_U_LUI];
    end

    always_comb begin
        imm32 = '0;
        if (illegal) begin
            imm32 = '0;
        end else if (hit[T_I_ALU64] || hit[T_I_ALU32] || hit[T_I_MEMLOAD] ||
                     hit[T_I_ENV] || hit[T_I_JALR]) begin
            imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        end else if (hit[T_S_STORE]) begin
            imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        end else if (hit[T_B_BRANCH]) begin
            imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                     in_inst[11:8], 1'b0};
        end else if (hit[T_U_AUIPC] || hit[T_U_LUI]) begin
            imm32 = {in_inst[31:12], 12'b0};
        end else if (hit[T_J_JAL]) begin
            imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                     in_inst[30:21], 1'b0};
        end
    end

    always_comb begin
        dec_entry         = '0;
        dec_entry.pc      = MAX_XLEN'(in_pc);
        dec_entry.rd      = in_inst[11:7];
        dec_entry.rs1     = in_inst[19:15];
        dec_entry.rs2     = in_inst[24:20];
        dec_entry.funct3  = in_inst[14:12];
        dec_entry.funct7  = in_inst[31:25];
        dec_entry.itype   = illegal ? '0 : hit;
        dec_entry.unit    = illegal ? '0 : unit;
        dec_entry.imm     = sext32(imm32);
        dec_entry.illegal = illegal;
    end

    decode_skid_buf #(
        .WIDTH($bits(entry_t))
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_entry)
    );

    assign out_pc      = out_entry.pc[XLEN-1:0];
    assign out_rd      = out_entry.rd;
    assign out_rs1     = out_entry.rs1;
    assign out_rs2     = out_entry.rs2;
    assign out_funct3  = out_entry.funct3;
    assign out_funct7  = out_entry.funct7;
    assign out_type    = out_entry.itype;
    assign out_unit    = out_entry.unit;
    assign out_imm     = out_entry.imm[XLEN-1:0];
    assign out_illegal = out_entry.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a 64-bit and a 32-bit instance share one
// input stream; decode vectors are table-driven, buffer corners hand-written.
`timescale 1ns/1ps
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic        out_ready;

    logic        in_ready, out_valid, out_illegal;
    logic [63:0] out_pc, out_imm;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [11:0] out_type;
    logic [4:0]  out_unit;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_pc32, out_imm32;
    logic [4:0]  out_rd32, out_rs1_32, out_rs2_32;
    logic [2:0]  out_funct3_32;
    logic [6:0]  out_funct7_32;
    logic [11:0] out_type32;
    logic [4:0]  out_unit32;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_type(out_type), .out_unit(out_unit), .out_imm(out_imm),
        .out_illegal(out_illegal)
    );

    decode_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst), .in_pc(in_pc[31:0]),
        .out_valid(out_valid32), .out_ready(out_ready), .out_pc(out_pc32),
        .out_rd(out_rd32), .out_rs1(out_rs1_32), .out_rs2(out_rs2_32),
        .out_funct3(out_funct3_32), .out_funct7(out_funct7_32),
        .out_type(out_type32), .out_unit(out_unit32), .out_imm(out_imm32),
        .out_illegal(out_illegal32)
    );

    typedef struct {
        logic [31:0] inst;
        logic [11:0] typ;
        logic [4:0]  unit;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic        ill64;
        logic        ill32;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [63:0] pc);
        in_valid = v;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    initial begin
        vecs[0]  = '{32'hFFF00093, 12'h200, 5'h10, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1,  1'b0, 1'b0}; // addi
        vecs[1]  = '{32'h800002B7, 12'h002, 5'h01, 64'hFFFF_FFFF_8000_0000, 5'd5,  1'b0, 1'b0}; // lui
        vecs[2]  = '{32'h0080006F, 12'h001, 5'h02, 64'h0000_0000_0000_0008, 5'd0,  1'b0, 1'b0}; // jal
        vecs[3]  = '{32'h0010809B, 12'h100, 5'h10, 64'h0000_0000_0000_0001, 5'd1,  1'b0, 1'b1}; // addiw
        vecs[4]  = '{32'h00000000, 12'h000, 5'h00, 64'h0,                   5'd0,  1'b1, 1'b1}; // low bits 00
        vecs[5]  = '{32'h0000000F, 12'h000, 5'h00, 64'h0,                   5'd0,  1'b1, 1'b1}; // unmapped
        vecs[6]  = '{32'hFE20AE23, 12'h010, 5'h08, 64'hFFFF_FFFF_FFFF_FFFC, 5'd28, 1'b0, 1'b0}; // sw -4
        vecs[7]  = '{32'hFE000CE3, 12'h008, 5'h02, 64'hFFFF_FFFF_FFFF_FFF8, 5'd25, 1'b0, 1'b0}; // beq -8
        vecs[8]  = '{32'h00001117, 12'h004, 5'h01, 64'h0000_0000_0000_1000, 5'd2,  1'b0, 1'b0}; // auipc
        vecs[9]  = '{32'h0080B183, 12'h080, 5'h08, 64'h0000_0000_0000_0008, 5'd3,  1'b0, 1'b0}; // ld
        vecs[10] = '{32'h00000073, 12'h040, 5'h04, 64'h0,                   5'd0,  1'b0, 1'b0}; // ecall
        vecs[11] = '{32'h000080E7, 12'h020, 5'h02, 64'h0,                   5'd1,  1'b0, 1'b0}; // jalr
        vecs[12] = '{32'h002081B3, 12'h800, 5'h10, 64'h0,                   5'd3,  1'b0, 1'b0}; // add
        vecs[13] = '{32'h002081BB, 12'h400, 5'h10, 64'h0,                   5'd3,  1'b0, 1'b1}; // addw

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 64'h0);
        #12;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset payload", {out_pc[31:0], out_imm[31:0]} | 64'(out_type) | 64'(out_rd), 64'd0);
        chk("reset out_valid32", 64'(out_valid32), 64'd0);
        #10 rst_n = 1'b1;
        step();

        // Streaming decode vectors, one per cycle with out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            logic [63:0] pc;
            logic [31:0] ins;
            pc  = 64'h8000_0000_0000_1000 + 64'(i * 4);
            ins = vecs[i].inst;
            drive(1'b1, ins, pc);
            step();
            $display("[TB] vec %0d inst=%h type=%h unit=%h imm=%h ill=%b ill32=%b",
                     i, ins, out_type, out_unit, out_imm, out_illegal, out_illegal32);
            chk($sformatf("v%0d valid", i), {62'd0, out_valid, in_ready}, 64'd3);
            chk($sformatf("v%0d type", i), 64'(out_type), 64'(vecs[i].typ));
            chk($sformatf("v%0d unit", i), 64'(out_unit), 64'(vecs[i].unit));
            chk($sformatf("v%0d imm", i), out_imm, vecs[i].imm);
            chk($sformatf("v%0d rd", i), 64'(out_rd), 64'(vecs[i].rd));
            chk($sformatf("v%0d fields", i), 64'({out_funct7, out_rs2, out_rs1, out_funct3}),
                64'({ins[31:25], ins[24:20], ins[19:15], ins[14:12]}));
            chk($sformatf("v%0d illegal", i), 64'(out_illegal), 64'(vecs[i].ill64));
            chk($sformatf("v%0d pc", i), out_pc, pc);
            chk($sformatf("v%0d type32", i), 64'(out_type32), vecs[i].ill32 ? 64'd0 : 64'(vecs[i].typ));
            chk($sformatf("v%0d unit32", i), 64'(out_unit32), vecs[i].ill32 ? 64'd0 : 64'(vecs[i].unit));
            chk($sformatf("v%0d imm32", i), 64'(out_imm32), vecs[i].ill32 ? 64'd0 : 64'(vecs[i].imm[31:0]));
            chk($sformatf("v%0d illegal32", i), 64'(out_illegal32), 64'(vecs[i].ill32));
            chk($sformatf("v%0d pc32", i), 64'(out_pc32), 64'(pc[31:0]));
        end
        drive(1'b0, 32'h0, 64'h0);
        step();
        chk("drain empty", 64'(out_valid), 64'd0);

        // Backpressure: three offered, two held, then released in order.
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 64'h2000);
        step();
        $display("[TB] bp accept A out_rd=%0d in_ready=%b", out_rd, in_ready);
        chk("bp A valid", {62'd0, out_valid, in_ready}, 64'd3);
        chk("bp A rd", 64'(out_rd), 64'd1);
        drive(1'b1, 32'h00200113, 64'h2004);
        step();
        $display("[TB] bp accept B out_rd=%0d in_ready=%b", out_rd, in_ready);
        chk("bp B full", {62'd0, out_valid, in_ready}, 64'd2);
        chk("bp B hold rd", 64'(out_rd), 64'd1);
        drive(1'b1, 32'h00300193, 64'h2008);
        step();
        $display("[TB] bp stall C out_rd=%0d in_ready=%b", out_rd, in_ready);
        chk("bp C stall", {62'd0, out_valid, in_ready}, 64'd2);
        chk("bp C hold pc", out_pc, 64'h2000);
        out_ready = 1'b1;
        step();
        $display("[TB] bp drain A out_rd=%0d in_ready=%b", out_rd, in_ready);
        chk("bp out B rd", 64'(out_rd), 64'd2);
        chk("bp out B ready", {62'd0, out_valid, in_ready}, 64'd3);
        step();
        $display("[TB] bp drain B out_rd=%0d", out_rd);
        chk("bp out C rd", 64'(out_rd), 64'd3);
        chk("bp out C pc", out_pc, 64'h2008);
        drive(1'b0, 32'h0, 64'h0);
        step();
        $display("[TB] bp drain C out_valid=%b", out_valid);
        chk("bp empty", 64'(out_valid), 64'd0);

        // Flush with both entries full and an input offered.
        out_ready = 1'b0;
        drive(1'b1, 32'h00400213, 64'h3000);
        step();
        drive(1'b1, 32'h00500293, 64'h3004);
        step();
        chk("fl full", {62'd0, out_valid, in_ready}, 64'd2);
        flush = 1'b1;
        drive(1'b1, 32'h00600313, 64'h3008);
        step();
        $display("[TB] flush full out_valid=%b in_ready=%b", out_valid, in_ready);
        chk("fl2 cleared", {62'd0, out_valid, in_ready}, 64'd1);
        flush = 1'b0;
        drive(1'b0, 32'h0, 64'h0);
        step();
        chk("fl2 stays empty", 64'(out_valid), 64'd0);

        // Flush with one entry while an accept completes: the accept is lost.
        drive(1'b1, 32'h00700393, 64'h300C);
        step();
        chk("fl1 one entry", {62'd0, out_valid, in_ready}, 64'd3);
        flush = 1'b1;
        drive(1'b1, 32'h00800413, 64'h3010);
        step();
        $display("[TB] flush one out_valid=%b in_ready=%b", out_valid, in_ready);
        chk("fl1 cleared", {62'd0, out_valid, in_ready}, 64'd1);
        flush = 1'b0;
        drive(1'b0, 32'h0, 64'h0);
        step();
        chk("fl1 accept dropped", 64'(out_valid), 64'd0);
        drive(1'b1, 32'h00900493, 64'h3014);
        step();
        $display("[TB] post-flush accept out_rd=%0d", out_rd);
        chk("fl post rd", {58'd0, out_valid, out_rd}, {58'd0, 1'b1, 5'd9});

        // Asynchronous reset with a full buffer.
        drive(1'b1, 32'h00A00513, 64'h4000);
        step();
        chk("rst pre full", {62'd0, out_valid, in_ready}, 64'd2);
        #3 rst_n = 1'b0;
        #1;
        $display("[TB] async reset out_valid=%b in_ready=%b pc=%h", out_valid, in_ready, out_pc);
        chk("rst async ctrl", {62'd0, out_valid, in_ready}, 64'd1);
        chk("rst async payload", out_pc | out_imm | 64'(out_rd) | 64'(out_type), 64'd0);
        drive(1'b0, 32'h0, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("rst no replay", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
